// File: rtl/pc_unit_pkg.sv
// Shared core definitions: address width, reset vector default,
// mtvec mode encodings and program-counter FSM states.
package pc_unit_pkg;

    localparam int          CORE_XLEN         = 32;
    localparam logic [31:0] CORE_RESET_VECTOR = 32'h0000_0000;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (trap > mret > branch > hold > sequential)
// with branch-target alignment checking.
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int XLEN   = CORE_XLEN,
    parameter int IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            step2,
    input  logic            hold,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap,
    input  logic            trap_is_irq,
    input  logic [4:0]      trap_cause,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] pc_seq,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect,
    output logic            misalign
);

    localparam logic [XLEN-1:0] AMASK = XLEN'(IALIGN - 1);

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] mret_tgt;
    logic            br_bad;

    assign step     = (IALIGN == 2 && step2) ? XLEN'(2) : XLEN'(4);
    assign pc_seq   = pc + step;
    assign base     = {mtvec[XLEN-1:2], 2'b00};
    assign mret_tgt = mepc & ~AMASK;
    assign br_bad   = |(br_target & AMASK);

    // Reserved mtvec modes fall back to direct.
    always_comb begin
        trap_tgt = base;
        if (mtvec[1:0] == MTVEC_VECTORED && trap_is_irq)
            trap_tgt = base + {{(XLEN-7){1'b0}}, trap_cause, 2'b00};
    end

    always_comb begin
        next_pc  = pc_seq;
        redirect = 1'b0;
        misalign = 1'b0;
        if (trap) begin
            next_pc  = trap_tgt;
            redirect = 1'b1;
        end else if (mret) begin
            next_pc  = mret_tgt;
            redirect = 1'b1;
        end else if (br_taken && br_bad) begin
            next_pc  = pc;
            misalign = 1'b1;
        end else if (br_taken) begin
            next_pc  = br_target;
            redirect = 1'b1;
        end else if (hold) begin
            next_pc  = pc;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run/halt FSM, PC register and
// valid/ready fetch request toward instruction fetch.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(CORE_RESET_VECTOR),
    parameter int              IALIGN       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_ready,
    input  logic            stall,
    input  logic            step2,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap,
    input  logic            trap_is_irq,
    input  logic [4:0]      trap_cause,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr,
    output logic            redirected
);

    pc_state_t       state, state_n;
    logic [XLEN-1:0] pc_n, maddr_n;
    logic            mis_n, redir_n;
    logic [XLEN-1:0] sel_pc;
    logic            sel_redir, sel_mis;

    pc_next_sel #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_sel (
        .pc          (pc_out),
        .step2       (step2),
        .hold        (stall | ~pc_ready),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap        (trap),
        .trap_is_irq (trap_is_irq),
        .trap_cause  (trap_cause),
        .mtvec       (mtvec),
        .mret        (mret),
        .mepc        (mepc),
        .pc_seq      (pc_next_seq),
        .next_pc     (sel_pc),
        .redirect    (sel_redir),
        .misalign    (sel_mis)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc_out;
        maddr_n = misalign_addr;
        mis_n   = 1'b0;
        redir_n = 1'b0;
        unique case (state)
            ST_BOOT: state_n = ST_RUN;
            ST_RUN: begin
                if (trap) begin
                    pc_n    = sel_pc;
                    redir_n = 1'b1;
                end else if (halt) begin
                    state_n = ST_HALT;
                end else begin
                    pc_n    = sel_pc;
                    redir_n = sel_redir;
                    mis_n   = sel_mis;
                    if (sel_mis) maddr_n = br_target;
                end
            end
            ST_HALT: begin
                // Only a trap (interrupt) wakes the core from WFI.
                if (trap) begin
                    state_n = ST_RUN;
                    pc_n    = sel_pc;
                    redir_n = 1'b1;
                end
            end
            default: state_n = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_BOOT;
            pc_out        <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
            redirected    <= 1'b0;
        end else begin
            state         <= state_n;
            pc_out        <= pc_n;
            pc_valid      <= (state_n == ST_RUN);
            misalign      <= mis_n;
            misalign_addr <= maddr_n;
            redirected    <= redir_n;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: vector table for the RUN-state
// priority mux, hand sequences for boot, compressed step and halt.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_ready, stall, step2, br_taken;
    logic [31:0] br_target;
    logic        trap, trap_is_irq;
    logic [4:0]  trap_cause;
    logic [31:0] mtvec, mepc;
    logic        mret, halt;

    logic [31:0] pc4, seq4, maddr4;
    logic        valid4, mis4, redir4;
    logic [31:0] pc2, seq2, maddr2;
    logic        valid2, mis2, redir2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4)) dut4 (
        .clk(clk), .reset(reset), .pc_ready(pc_ready), .stall(stall),
        .step2(step2), .br_taken(br_taken), .br_target(br_target),
        .trap(trap), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
        .mtvec(mtvec), .mret(mret), .mepc(mepc), .halt(halt),
        .pc_out(pc4), .pc_valid(valid4), .pc_next_seq(seq4),
        .misalign(mis4), .misalign_addr(maddr4), .redirected(redir4)
    );

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2)) dut2 (
        .clk(clk), .reset(reset), .pc_ready(pc_ready), .stall(stall),
        .step2(step2), .br_taken(br_taken), .br_target(br_target),
        .trap(trap), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
        .mtvec(mtvec), .mret(mret), .mepc(mepc), .halt(halt),
        .pc_out(pc2), .pc_valid(valid2), .pc_next_seq(seq2),
        .misalign(mis2), .misalign_addr(maddr2), .redirected(redir2)
    );

    typedef struct {
        logic        br;
        logic [31:0] tgt;
        logic        trap;
        logic        irq;
        logic [4:0]  cause;
        logic [31:0] mtvec;
        logic        mret;
        logic [31:0] mepc;
        logic        stall;
        logic        ready;
        logic [31:0] e_pc;
        logic        e_mis;
        logic        e_redir;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        logic br, logic [31:0] tgt, logic tr, logic irq, logic [4:0] cause,
        logic [31:0] mtv, logic mr, logic [31:0] mep, logic st, logic rdy,
        logic [31:0] e_pc, logic e_mis, logic e_redir, logic [31:0] e_maddr);
        vec_t v;
        v.br = br; v.tgt = tgt; v.trap = tr; v.irq = irq; v.cause = cause;
        v.mtvec = mtv; v.mret = mr; v.mepc = mep; v.stall = st;
        v.ready = rdy; v.e_pc = e_pc; v.e_mis = e_mis;
        v.e_redir = e_redir; v.e_maddr = e_maddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; step2 = 0; br_taken = 0; br_target = 0;
        trap = 0; trap_is_irq = 0; trap_cause = 0; mtvec = 0;
        mret = 0; mepc = 0; halt = 0; pc_ready = 1;
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0, 0, 0);
        vecs[4]  = mk(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h84, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h84, 0, 0, 0);
        vecs[7]  = mk(1, 32'h42, 0, 0, 0, 0, 0, 0, 0, 1, 32'h84, 1, 0, 32'h42);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88, 0, 0, 32'h42);
        vecs[9]  = mk(1, 32'h42, 1, 0, 0, 32'h1001, 0, 0, 0, 1,
                      32'h1000, 0, 1, 32'h42);
        vecs[10] = mk(0, 0, 1, 1, 5'd7, 32'h1001, 0, 0, 0, 1,
                      32'h101C, 0, 1, 32'h42);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 32'h203, 0, 1,
                      32'h200, 0, 1, 32'h42);
        vecs[12] = mk(1, 32'h300, 1, 0, 0, 32'h500, 1, 32'h900, 0, 1,
                      32'h500, 0, 1, 32'h42);
        vecs[13] = mk(0, 0, 1, 0, 0, 32'h600, 0, 0, 1, 0,
                      32'h600, 0, 1, 32'h42);
        vecs[14] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 1,
                      32'hFFFF_FFFC, 0, 1, 32'h42);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 32'h42);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 32'h7, 0, 0, 32'h4, 0, 1, 32'h42);

        idle();
        reset = 0;
        tick();
        tick();
        chk("rst_pc", pc4, 32'h0);
        chk("rst_valid", {31'b0, valid4}, 32'h0);
        chk("rst_mis", {31'b0, mis4}, 32'h0);
        chk("rst_maddr", maddr4, 32'h0);
        chk("rst_redir", {31'b0, redir4}, 32'h0);

        reset = 1;
        chk("boot_valid", {31'b0, valid4}, 32'h0);
        tick();
        chk("run_valid", {31'b0, valid4}, 32'h1);
        chk("run_pc0", pc4, 32'h0);
        tick();
        chk("run_pc4", pc4, 32'h4);
        tick();
        chk("run_pc8", pc4, 32'h8);
        chk("run_seq", seq4, 32'hC);

        for (int i = 0; i < 17; i++) begin
            br_taken = vecs[i].br;     br_target   = vecs[i].tgt;
            trap     = vecs[i].trap;   trap_is_irq = vecs[i].irq;
            trap_cause = vecs[i].cause; mtvec      = vecs[i].mtvec;
            mret     = vecs[i].mret;   mepc        = vecs[i].mepc;
            stall    = vecs[i].stall;  pc_ready    = vecs[i].ready;
            tick();
            chk($sformatf("v%0d_pc", i), pc4, vecs[i].e_pc);
            chk($sformatf("v%0d_mis", i), {31'b0, mis4},
                {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d_redir", i), {31'b0, redir4},
                {31'b0, vecs[i].e_redir});
            chk($sformatf("v%0d_maddr", i), maddr4, vecs[i].e_maddr);
            chk($sformatf("v%0d_seq", i), seq4, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d_valid", i), {31'b0, valid4}, 32'h1);
        end

        idle();
        br_taken = 1; br_target = 32'h100;
        tick();
        chk("c_pc4_base", pc4, 32'h100);
        chk("c_pc2_base", pc2, 32'h100);
        br_taken = 0; step2 = 1;
        tick();
        chk("c_pc4_step", pc4, 32'h104);
        chk("c_pc2_step1", pc2, 32'h102);
        tick();
        chk("c_pc2_step2", pc2, 32'h104);
        chk("c_seq2", seq2, 32'h106);
        chk("c_seq4", seq4, 32'h10C);
        step2 = 0; br_taken = 1; br_target = 32'h101;
        tick();
        chk("c2_mis_pc", pc2, 32'h104);
        chk("c2_mis", {31'b0, mis2}, 32'h1);
        chk("c2_maddr", maddr2, 32'h101);
        br_taken = 0; mret = 1; mepc = 32'h203;
        tick();
        chk("c2_mret", pc2, 32'h202);
        chk("c4_mret", pc4, 32'h200);

        idle();
        br_taken = 1; br_target = 32'h40;
        tick();
        br_taken = 0; halt = 1;
        tick();
        chk("h_valid", {31'b0, valid4}, 32'h0);
        chk("h_pc", pc4, 32'h40);
        halt = 0; br_taken = 1; br_target = 32'h80;
        tick();
        chk("h_br_pc", pc4, 32'h40);
        chk("h_br_redir", {31'b0, redir4}, 32'h0);
        br_taken = 0; mret = 1; mepc = 32'h300;
        tick();
        chk("h_mret_pc", pc4, 32'h40);
        chk("h_mret_valid", {31'b0, valid4}, 32'h0);
        mret = 0; trap = 1; mtvec = 32'h500;
        tick();
        chk("h_wake_pc", pc4, 32'h500);
        chk("h_wake_valid", {31'b0, valid4}, 32'h1);
        chk("h_wake_redir", {31'b0, redir4}, 32'h1);
        halt = 1; mtvec = 32'h600;
        tick();
        chk("th_pc", pc4, 32'h600);
        chk("th_valid", {31'b0, valid4}, 32'h1);
        trap = 0;
        tick();
        chk("h2_valid", {31'b0, valid4}, 32'h0);
        halt = 0;
        #2;
        reset = 0;
        #1;
        chk("arst_pc", pc4, 32'h0);
        chk("arst_valid", {31'b0, valid4}, 32'h0);
        tick();
        reset = 1;
        tick();
        chk("reboot_valid", {31'b0, valid4}, 32'h1);
        chk("reboot_pc", pc4, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
